// File: rtl/kb_matrix_scan.sv
// Column-scanned ROWS x COLS key matrix with whole-frame debounce.
// Reports one committed key (or none / multi-key) with press and release strobes.
module kb_matrix_scan #(
    parameter int ROWS     = 5,
    parameter int COLS     = 5,
    parameter int DEBOUNCE = 4,
    parameter int CODE_W   = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              scan_tick,
    input  logic [ROWS-1:0]   k_row,
    output logic [COLS-1:0]   k_col,
    output logic [CODE_W-1:0] key_code,
    output logic              key_valid,
    output logic              key_release,
    output logic              key_down,
    output logic              key_multi
);

    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int SW = $clog2(DEBOUNCE + 1);

    typedef enum logic [1:0] {R_NONE, R_SINGLE, R_MULTI} kind_t;
    typedef struct packed {
        kind_t             kind;
        logic [CODE_W-1:0] code;
    } res_t;

    logic [ROWS-1:0]   row_s1, row_s2;
    logic [CW-1:0]     col_idx, col_next;
    logic              last_col;
    logic [1:0]        samp_cnt, acc_cnt, acc_cnt_n;
    logic [CODE_W-1:0] samp_code, acc_code, acc_code_n;
    res_t              res, cand, cand_n, committed;
    logic [SW-1:0]     stable_cnt, stable_cnt_n;
    logic              commit;

    assign last_col = (col_idx == CW'(COLS - 1));
    assign col_next = last_col ? '0 : col_idx + 1'b1;

    // Low-bit count saturates at 2: only none / one / many matters.
    always_comb begin
        samp_cnt  = 2'd0;
        samp_code = '0;
        for (int r = ROWS - 1; r >= 0; r--) begin
            if (!row_s2[r]) begin
                samp_code = CODE_W'(int'(col_idx) * ROWS + r);
                if (samp_cnt != 2'd2) samp_cnt = samp_cnt + 2'd1;
            end
        end
    end

    always_comb begin
        acc_cnt_n  = (acc_cnt + samp_cnt > 2'd2 || acc_cnt == 2'd2) ? 2'd2 : acc_cnt + samp_cnt;
        acc_code_n = (acc_cnt == 2'd0) ? samp_code : acc_code;
        res.code   = '0;
        case (acc_cnt_n)
            2'd0:    res.kind = R_NONE;
            2'd1:    begin res.kind = R_SINGLE; res.code = acc_code_n; end
            default: res.kind = R_MULTI;
        endcase
    end

    always_comb begin
        cand_n       = res;
        stable_cnt_n = SW'(1);
        if (res == cand)
            stable_cnt_n = (stable_cnt == SW'(DEBOUNCE)) ? stable_cnt : stable_cnt + 1'b1;
        commit = (stable_cnt_n == SW'(DEBOUNCE)) && (cand_n != committed);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_s1      <= '1;
            row_s2      <= '1;
            col_idx     <= '0;
            k_col       <= ~COLS'(1);
            acc_cnt     <= 2'd0;
            acc_code    <= '0;
            cand        <= '{kind: R_NONE, code: '0};
            committed   <= '{kind: R_NONE, code: '0};
            stable_cnt  <= '0;
            key_code    <= '0;
            key_valid   <= 1'b0;
            key_release <= 1'b0;
            key_down    <= 1'b0;
            key_multi   <= 1'b0;
        end else begin
            row_s1      <= k_row;
            row_s2      <= row_s1;
            key_valid   <= 1'b0;
            key_release <= 1'b0;
            if (scan_tick) begin
                col_idx <= col_next;
                k_col   <= ~(COLS'(1) << col_next);
                if (!last_col) begin
                    acc_cnt  <= acc_cnt_n;
                    acc_code <= acc_code_n;
                end else begin
                    acc_cnt    <= 2'd0;
                    acc_code   <= '0;
                    cand       <= cand_n;
                    stable_cnt <= stable_cnt_n;
                    if (commit) begin
                        committed <= cand_n;
                        case (cand_n.kind)
                            R_SINGLE: begin
                                key_code  <= cand_n.code;
                                key_down  <= 1'b1;
                                key_multi <= 1'b0;
                                key_valid <= 1'b1;
                            end
                            R_MULTI: begin
                                key_multi   <= 1'b1;
                                key_down    <= 1'b0;
                                key_release <= (committed.kind == R_SINGLE);
                            end
                            default: begin
                                key_multi   <= 1'b0;
                                key_down    <= 1'b0;
                                key_release <= (committed.kind == R_SINGLE);
                            end
                        endcase
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_kb_matrix_scan.sv
// Bench for kb_matrix_scan: two configurations driven by a simulated key matrix,
// checked every cycle against a frame-history model plus literal expectations.
module tb_kb_matrix_scan;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic        scan_tick = 1'b0;
    logic [31:0] pa = '0, pb = '0;

    logic [4:0] k_row_a, k_col_a, code_a;
    logic       va, ra, da, ma;
    logic [3:0] k_row_b;
    logic [2:0] k_col_b;
    logic [4:0] code_b;
    logic       vb, rb, db, mb;

    int n_cmp = 0, n_bad = 0;

    // Passive matrix: a row reads low when a pressed key joins it to the driven column.
    always_comb begin
        k_row_a = '1;
        for (int c = 0; c < 5; c++)
            for (int r = 0; r < 5; r++)
                if (!k_col_a[c] && pa[c*5+r]) k_row_a[r] = 1'b0;
    end
    always_comb begin
        k_row_b = '1;
        for (int c = 0; c < 3; c++)
            for (int r = 0; r < 4; r++)
                if (!k_col_b[c] && pb[c*4+r]) k_row_b[r] = 1'b0;
    end

    kb_matrix_scan #(.ROWS(5), .COLS(5), .DEBOUNCE(4), .CODE_W(5)) dut_a (
        .clk(clk), .rst(rst), .scan_tick(scan_tick), .k_row(k_row_a), .k_col(k_col_a),
        .key_code(code_a), .key_valid(va), .key_release(ra), .key_down(da), .key_multi(ma));

    kb_matrix_scan #(.ROWS(4), .COLS(3), .DEBOUNCE(1), .CODE_W(5)) dut_b (
        .clk(clk), .rst(rst), .scan_tick(scan_tick), .k_row(k_row_b), .k_col(k_col_b),
        .key_code(code_b), .key_valid(vb), .key_release(rb), .key_down(db), .key_multi(mb));

    // Model: results are -1 none, -2 multi, else key code.
    function automatic int nrows(int i); return (i == 0) ? 5 : 4; endfunction
    function automatic int ncols(int i); return (i == 0) ? 5 : 3; endfunction
    function automatic int ndeb(int i);  return (i == 0) ? 4 : 1; endfunction

    int mcol[2]   = '{0, 0};
    int cm[2]     = '{-1, -1};
    int hlen[2]   = '{0, 0};
    int hist[2][16];
    int e_code[2] = '{0, 0};
    bit e_v[2], e_r[2], e_d[2], e_m[2];

    task automatic frame_close(input int i);
        logic [31:0] p;
        int n, code, res;
        bit stable;
        p = (i == 0) ? pa : pb;
        n = 0; code = -1;
        for (int k = 0; k < nrows(i) * ncols(i); k++)
            if (p[k]) begin n++; code = k; end
        res = (n == 0) ? -1 : (n == 1) ? code : -2;
        for (int j = 15; j > 0; j--) hist[i][j] = hist[i][j-1];
        hist[i][0] = res;
        if (hlen[i] < 16) hlen[i]++;
        stable = (hlen[i] >= ndeb(i));
        for (int j = 0; j < ndeb(i); j++)
            if (hist[i][j] != res) stable = 0;
        if (stable && res != cm[i]) begin
            if (res >= 0) begin
                e_code[i] = res; e_d[i] = 1; e_m[i] = 0; e_v[i] = 1;
            end else begin
                e_r[i] = (cm[i] >= 0); e_d[i] = 0; e_m[i] = (res == -2);
            end
            cm[i] = res;
        end
    endtask

    always @(posedge clk or posedge rst) begin
        for (int i = 0; i < 2; i++) begin
            e_v[i] = 0; e_r[i] = 0;
            if (rst) begin
                mcol[i] = 0; cm[i] = -1; hlen[i] = 0;
                e_code[i] = 0; e_d[i] = 0; e_m[i] = 0;
            end else if (scan_tick) begin
                if (mcol[i] == ncols(i) - 1) begin
                    mcol[i] = 0;
                    frame_close(i);
                end else mcol[i]++;
            end
        end
    end

    task automatic cycle_check;
        int ac, ec, acol, ecol;
        bit av, ar, ad, am;
        for (int i = 0; i < 2; i++) begin
            if (i == 0) begin ac = int'(code_a); av = va; ar = ra; ad = da; am = ma; acol = int'(k_col_a); end
            else        begin ac = int'(code_b); av = vb; ar = rb; ad = db; am = mb; acol = int'(k_col_b); end
            ec   = e_code[i];
            ecol = ~(1 << mcol[i]) & ((1 << ncols(i)) - 1);
            n_cmp++;
            if (ac != ec || av != e_v[i] || ar != e_r[i] || ad != e_d[i] || am != e_m[i] || acol != ecol) begin
                n_bad++;
                $display("FAIL cycle_inst%0d t=%0t got code=%0d v=%0b r=%0b d=%0b m=%0b col=%0h want code=%0d v=%0b r=%0b d=%0b m=%0b col=%0h",
                         i, $time, ac, av, ar, ad, am, acol, ec, e_v[i], e_r[i], e_d[i], e_m[i], ecol);
            end
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic step;
        @(negedge clk);
        cycle_check();
        @(posedge clk);
        #1;
    endtask

    task automatic tick;
        repeat (3) step();
        scan_tick = 1'b1;
        step();
        scan_tick = 1'b0;
    endtask

    task automatic frames(input int n);
        repeat (n * 5) tick();
    endtask

    initial begin
        // Reset with junk on the rows and ticks running.
        for (int k = 0; k < 8; k++) begin
            pa = $urandom; pb = $urandom;
            scan_tick = k[0];
            step();
        end
        scan_tick = 1'b0; pa = '0; pb = '0;
        chk("rst_kcol_a", int'(k_col_a), 5'b11110);
        chk("rst_kcol_b", int'(k_col_b), 3'b110);
        chk("rst_flags_a", int'({va, ra, da, ma}), 0);
        chk("rst_code_a", int'(code_a), 0);
        rst = 1'b0;
        repeat (3) step();
        tick();
        chk("first_tick_kcol", int'(k_col_a), 5'b11101);
        repeat (4) tick();

        // Single key at code 17 (col 3, row 2).
        pa = 32'd1 << 17;
        frames(3);
        chk("press_early_down", int'(da), 0);
        frames(1);
        chk("press_valid", int'(va), 1);
        chk("press_code", int'(code_a), 17);
        chk("press_down", int'(da), 1);
        step();
        chk("press_valid_1clk", int'(va), 0);
        pa = '0;
        frames(4);
        chk("release_pulse", int'(ra), 1);
        chk("release_down", int'(da), 0);
        chk("release_code_held", int'(code_a), 17);

        // Bounce: 3 low, 1 high, then low again.
        pa = 32'd1 << 17; frames(3);
        pa = '0;          frames(1);
        pa = 32'd1 << 17; frames(3);
        chk("bounce_no_commit", int'(da), 0);
        frames(1);
        chk("bounce_valid", int'(va), 1);

        // Multi-key from none, then back to a single key.
        pa = '0; frames(4);
        chk("pre_multi_release", int'(ra), 1);
        pa = (32'd1 << 17) | (32'd1 << 3); frames(4);
        chk("multi_flag", int'(ma), 1);
        chk("multi_no_valid", int'(va), 0);
        chk("multi_down", int'(da), 0);
        chk("multi_code_held", int'(code_a), 17);
        pa = 32'd1 << 17; frames(4);
        chk("multi_to_single_valid", int'(va), 1);
        chk("multi_to_single_code", int'(code_a), 17);
        chk("multi_to_single_mflag", int'(ma), 0);

        // Direct switch between single keys, then single to multi.
        pa = 32'd1 << 6; frames(4);
        chk("switch_valid", int'(va), 1);
        chk("switch_code", int'(code_a), 6);
        chk("switch_no_release", int'(ra), 0);
        pa = (32'd1 << 6) | (32'd1 << 20); frames(4);
        chk("single_to_multi_release", int'(ra), 1);
        chk("single_to_multi_flag", int'(ma), 1);
        pa = '0; frames(4);
        chk("multi_to_none_no_release", int'(ra), 0);
        chk("multi_to_none_flag", int'(ma), 0);

        // Small configuration, DEBOUNCE=1, key at col 2 row 3.
        rst = 1'b1; step(); rst = 1'b0;
        pb = 32'd1 << 11;
        repeat (2) step();
        tick(); chk("b_kcol_1", int'(k_col_b), 3'b101);
        tick(); chk("b_kcol_2", int'(k_col_b), 3'b011);
        tick(); chk("b_kcol_wrap", int'(k_col_b), 3'b110);
        chk("b_valid", int'(vb), 1);
        chk("b_code", int'(code_b), 11);
        tick();
        rst = 1'b1;
        #1;
        chk("midrst_kcol_b", int'(k_col_b), 3'b110);
        chk("midrst_kcol_a", int'(k_col_a), 5'b11110);
        chk("midrst_flags_b", int'({vb, rb, db, mb}), 0);
        chk("midrst_code_b", int'(code_b), 0);
        step(); rst = 1'b0;
        repeat (3) step();
        chk("rst_release_no_pulse", int'({vb, rb}), 0);
        repeat (3) tick();
        chk("b_recommit_valid", int'(vb), 1);
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
